// File: rtl/histo_frame_sequencer_pkg.sv
// Shared types and constants for the gray-level histogram frame sequencer.
// The state codes are plain constants so older tools can consume them.
package histo_frame_sequencer_pkg;

  localparam int HIST_BINS = 256;
  localparam int BIN_W     = 20;
  localparam int GRAY_W    = 8;
  localparam int ADDR_W    = GRAY_W + 1;

  localparam logic [BIN_W-1:0] BIN_MAX = '1;

  typedef logic [2:0] state_t;

  localparam state_t ST_INIT_CLR = 3'd0;
  localparam state_t ST_IDLE     = 3'd1;
  localparam state_t ST_ACCUM    = 3'd2;
  localparam state_t ST_DRAIN    = 3'd3;
  localparam state_t ST_SCAN     = 3'd4;
  localparam state_t ST_CLEAR    = 3'd5;

  function automatic logic [BIN_W-1:0] sat_add(input logic [BIN_W-1:0] a,
                                               input logic [BIN_W-1:0] b);
    logic [BIN_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BIN_W] ? BIN_MAX : s[BIN_W-1:0];
  endfunction

endpackage

// File: rtl/histo_frame_sequencer_if.sv
// Pixel, display and histogram-RAM signals of the histogram frame sequencer.
// master = environment side (pixel source, display client, RAM), slave = sequencer.
interface histo_frame_sequencer_if;
  import histo_frame_sequencer_pkg::*;

  logic              iFval;
  logic [GRAY_W-1:0] iGray;
  logic              iGrayValid;
  logic              iDispReq;
  logic [GRAY_W-1:0] iDispAddr;
  logic [BIN_W-1:0]  oDispQ;
  logic              oDispValid;
  logic [ADDR_W-1:0] oRdAddr;
  logic [BIN_W-1:0]  iRdQ;
  logic [ADDR_W-1:0] oWrAddr;
  logic [BIN_W-1:0]  oWrData;
  logic              oWe;
  logic [GRAY_W-1:0] oThresh;
  logic [BIN_W-1:0]  oMaxValue;
  logic              oDone;
  logic              oFrameDrop;
  logic              oBusy;

  modport master (
    output iFval, iGray, iGrayValid, iDispReq, iDispAddr, iRdQ,
    input  oDispQ, oDispValid, oRdAddr, oWrAddr, oWrData, oWe,
    input  oThresh, oMaxValue, oDone, oFrameDrop, oBusy
  );

  modport slave (
    input  iFval, iGray, iGrayValid, iDispReq, iDispAddr, iRdQ,
    output oDispQ, oDispValid, oRdAddr, oWrAddr, oWrData, oWe,
    output oThresh, oMaxValue, oDone, oFrameDrop, oBusy
  );

endinterface

// File: rtl/histo_frame_sequencer_rmw_pipe.sv
// Two-stage read-modify-write of histogram bins: read in t, saturating +1 write in t+1.
// Back-to-back hits on one bin take the previous write value, since the RAM read is read-first.
module histo_rmw_pipe
  import histo_frame_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_vld,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic [BIN_W-1:0]  rd_q,
  output logic              we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BIN_W-1:0]  wr_dat
);

  logic              s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              wb_vld_q, wb_vld_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [BIN_W-1:0]  wb_dat_q, wb_dat_d;
  logic              fwd;
  logic [BIN_W-1:0]  base;

  always_comb begin
    fwd       = wb_vld_q && (wb_addr_q == s1_addr_q);
    base      = fwd ? wb_dat_q : rd_q;
    we        = s1_vld_q;
    wr_addr   = s1_addr_q;
    wr_dat    = sat_add(base, {{(BIN_W-1){1'b0}}, 1'b1});
    s1_vld_d  = pix_vld;
    s1_addr_d = pix_addr;
    wb_vld_d  = s1_vld_q;
    wb_addr_d = s1_addr_q;
    wb_dat_d  = wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_dat_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      wb_vld_q  <= wb_vld_d;
      wb_addr_q <= wb_addr_d;
      wb_dat_q  <= wb_dat_d;
    end
  end

endmodule

// File: rtl/histo_frame_sequencer.sv
// Gray histogram sequencer: accumulates a frame into one RAM bank, scans it for max and
// threshold bin, clears it, and serves display reads from the other bank on free read slots.
module histo_frame_sequencer
  import histo_frame_sequencer_pkg::*;
#(
  parameter logic [BIN_W-1:0] THRESH_TARGET = 20'd192000
) (
  input logic                   iClk,
  input logic                   iRst_n,
  histo_frame_sequencer_if.slave bus
);

  state_t            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              acc_bank_q, acc_bank_d;
  logic              fval_q, fval_d;
  logic              arm_q, arm_d;
  logic [BIN_W-1:0]  sum_q, sum_d;
  logic [BIN_W-1:0]  max_q, max_d;
  logic [GRAY_W-1:0] thr_q, thr_d;
  logic              found_q, found_d;
  logic [GRAY_W-1:0] thresh_q, thresh_d;
  logic [BIN_W-1:0]  max_value_q, max_value_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              disp_vld_q, disp_vld_d;

  logic              rise, fall, pix_rd, scan_rd, hit;
  logic [GRAY_W-1:0] scan_bin;
  logic [BIN_W-1:0]  sum_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              rmw_we;
  logic [ADDR_W-1:0] rmw_addr;
  logic [BIN_W-1:0]  rmw_dat;

  histo_rmw_pipe u_rmw (
    .clk      (iClk),
    .rst_n    (iRst_n),
    .pix_vld  (pix_rd),
    .pix_addr ({acc_bank_q, bus.iGray}),
    .rd_q     (bus.iRdQ),
    .we       (rmw_we),
    .wr_addr  (rmw_addr),
    .wr_dat   (rmw_dat)
  );

  // Read port: pixel and scan reads own it; display takes whatever slot is left.
  always_comb begin
    rise       = bus.iFval & ~fval_q;
    fall       = ~bus.iFval & fval_q;
    fval_d     = bus.iFval;
    arm_d      = 1'b1;
    pix_rd     = (state_q == ST_ACCUM) & bus.iGrayValid;
    scan_rd    = (state_q == ST_SCAN) & ~cnt_q[8];
    disp_vld_d = bus.iDispReq & ~pix_rd & ~scan_rd;
    if (pix_rd) begin
      rd_addr = {acc_bank_q, bus.iGray};
    end else if (scan_rd) begin
      rd_addr = {acc_bank_q, cnt_q[7:0]};
    end else begin
      rd_addr = {~acc_bank_q, bus.iDispAddr};
    end
  end

  // Scan data for bin (cnt-1) arrives one cycle after its read; cnt==256 carries bin 255.
  always_comb begin
    scan_bin = cnt_q[7:0] - 8'd1;
    sum_nxt  = sat_add(sum_q, bus.iRdQ);
    hit      = ~found_q & (sum_nxt >= THRESH_TARGET);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_bank_d  = acc_bank_q;
    sum_d       = sum_q;
    max_d       = max_q;
    thr_d       = thr_q;
    found_d     = found_q;
    thresh_d    = thresh_q;
    max_value_d = max_value_q;
    done_d      = 1'b0;
    drop_d      = rise & (state_q != ST_IDLE) & (state_q != ST_ACCUM);
    clr_we      = 1'b0;
    clr_addr    = '0;
    case (state_q)
      ST_INIT_CLR: begin
        if (arm_q) begin
          clr_we   = 1'b1;
          clr_addr = cnt_q;
          if (cnt_q == 9'd511) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end
      end
      ST_IDLE: begin
        if (rise) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (fall) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Two cycles let the last pixel's write land before the scan reads.
        if (cnt_q[0]) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          sum_d   = '0;
          max_d   = '0;
          thr_d   = 8'd255;
          found_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_SCAN: begin
        if (cnt_q != 9'd0) begin
          sum_d = sum_nxt;
          if (bus.iRdQ > max_q) max_d = bus.iRdQ;
          if (hit) begin
            found_d = 1'b1;
            thr_d   = scan_bin;
          end
        end
        if (cnt_q == 9'd256) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          thresh_d    = thr_d;
          max_value_d = max_d;
          done_d      = 1'b1;
          acc_bank_d  = ~acc_bank_q;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_CLEAR: begin
        clr_we   = 1'b1;
        clr_addr = {acc_bank_q, cnt_q[7:0]};
        if (cnt_q == 9'd255) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: begin
        state_d = ST_INIT_CLR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= ST_INIT_CLR;
      cnt_q       <= '0;
      acc_bank_q  <= 1'b0;
      fval_q      <= 1'b0;
      arm_q       <= 1'b0;
      sum_q       <= '0;
      max_q       <= '0;
      thr_q       <= '0;
      found_q     <= 1'b0;
      thresh_q    <= '0;
      max_value_q <= '0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      disp_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_bank_q  <= acc_bank_d;
      fval_q      <= fval_d;
      arm_q       <= arm_d;
      sum_q       <= sum_d;
      max_q       <= max_d;
      thr_q       <= thr_d;
      found_q     <= found_d;
      thresh_q    <= thresh_d;
      max_value_q <= max_value_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      disp_vld_q  <= disp_vld_d;
    end
  end

  assign bus.oRdAddr    = rd_addr;
  assign bus.oWe        = rmw_we | clr_we;
  assign bus.oWrAddr    = rmw_we ? rmw_addr : clr_addr;
  assign bus.oWrData    = rmw_we ? rmw_dat : '0;
  assign bus.oDispValid = disp_vld_q;
  assign bus.oDispQ     = disp_vld_q ? bus.iRdQ : '0;
  assign bus.oThresh    = thresh_q;
  assign bus.oMaxValue  = max_value_q;
  assign bus.oDone      = done_q;
  assign bus.oFrameDrop = drop_q;
  assign bus.oBusy      = (state_q != ST_IDLE) && (state_q != ST_ACCUM);

endmodule

// File: tb/tb_histo_frame_sequencer.sv
// Randomized bench for histo_frame_sequencer: two instances (default and small threshold target)
// share stimulus, each with its own RAM; results are compared against a per-frame histogram model.
module tb_histo_frame_sequencer;

  logic       clk;
  logic       rst_n;
  logic       fval, gvld, dreq;
  logic [7:0] gray, daddr;

  int n_chk = 0;
  int n_bad = 0;
  int drop_cnt = 0;
  int pixq[$];
  int cur_hist[256];
  int prev_hist[256];
  bit exp_bank;

  logic [19:0] mem_a [0:511];
  logic [19:0] mem_b [0:511];

  histo_frame_sequencer_if bus_a();
  histo_frame_sequencer_if bus_b();

  assign bus_a.iFval = fval;      assign bus_b.iFval = fval;
  assign bus_a.iGray = gray;      assign bus_b.iGray = gray;
  assign bus_a.iGrayValid = gvld; assign bus_b.iGrayValid = gvld;
  assign bus_a.iDispReq = dreq;   assign bus_b.iDispReq = dreq;
  assign bus_a.iDispAddr = daddr; assign bus_b.iDispAddr = daddr;

  histo_frame_sequencer dut_a (.iClk(clk), .iRst_n(rst_n), .bus(bus_a));
  histo_frame_sequencer #(.THRESH_TARGET(20'd10)) dut_b (.iClk(clk), .iRst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous RAMs with one cycle of read latency.
  always @(posedge clk) begin
    bus_a.iRdQ <= mem_a[bus_a.oRdAddr];
    if (bus_a.oWe) mem_a[bus_a.oWrAddr] <= bus_a.oWrData;
    bus_b.iRdQ <= mem_b[bus_b.oRdAddr];
    if (bus_b.oWe) mem_b[bus_b.oWrAddr] <= bus_b.oWrData;
  end

  always @(negedge clk) if (bus_a.oFrameDrop === 1'b1) drop_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_thresh(input int tgt);
    int s = 0;
    for (int b = 0; b < 256; b++) begin
      s += cur_hist[b];
      if (s >= tgt) return b;
    end
    return 255;
  endfunction

  function automatic int model_max();
    int m = 0;
    foreach (cur_hist[b]) if (cur_hist[b] > m) m = cur_hist[b];
    return m;
  endfunction

  task automatic reset_checks();
    chk("rst_we", bus_a.oWe, 0);
    chk("rst_done", bus_a.oDone, 0);
    chk("rst_drop", bus_a.oFrameDrop, 0);
    chk("rst_dvld", bus_a.oDispValid, 0);
    chk("rst_dq", bus_a.oDispQ, 0);
    chk("rst_thr", bus_a.oThresh, 0);
    chk("rst_max", bus_a.oMaxValue, 0);
    chk("rst_busy", bus_a.oBusy, 1);
  endtask

  task automatic init_check();
    int n, bad, cyc;
    n = 0; bad = 0; cyc = 0;
    while (bus_a.oBusy === 1'b1 && cyc < 700) begin
      if (bus_a.oWe === 1'b1) begin
        if (bus_a.oWrAddr !== n[8:0] || bus_a.oWrData !== 20'd0) bad++;
        n++;
      end
      tick();
      cyc++;
    end
    chk("init_writes", n, 512);
    chk("init_order", bad, 0);
    chk("init_idle", bus_a.oBusy, 0);
    foreach (prev_hist[b]) prev_hist[b] = 0;
    exp_bank = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    pixq.delete();
    for (int k = 0; k < n; k++)
      pixq.push_back(($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(7)));
  endtask

  task automatic read_all();
    for (int b = 0; b < 256; b++) begin
      dreq = 1'b1;
      daddr = b[7:0];
      tick();
      chk("rb_vld", bus_a.oDispValid, 1);
      chk("rb_a", bus_a.oDispQ, prev_hist[b]);
      chk("rb_b", bus_b.oDispQ, prev_hist[b]);
    end
    dreq = 1'b0;
  endtask

  task automatic run_frame(input int duty, input bit disp, input bit intrude);
    int i, cyc;
    bit pv;
    foreach (cur_hist[b]) cur_hist[b] = 0;
    fval = 1'b1;
    tick();
    i = 0;
    while (i < pixq.size()) begin
      pv = ($urandom_range(99) < duty);
      gvld = pv;
      if (pv) begin
        gray = pixq[i][7:0];
        cur_hist[pixq[i]]++;
        i++;
      end
      dreq = disp;
      daddr = 8'($urandom_range(255));
      #1;
      if (pv) chk("rdaddr", bus_a.oRdAddr, {exp_bank, gray});
      tick();
      if (disp) begin
        chk("dgrant", bus_a.oDispValid, !pv);
        if (!pv) chk("dispq", bus_a.oDispQ, prev_hist[daddr]);
      end
    end
    gvld = 1'b0; dreq = 1'b0; fval = 1'b0;
    tick();
    cyc = 0;
    while (bus_a.oDone !== 1'b1 && cyc < 400) begin
      if (intrude) begin
        if (cyc == 40) fval = 1'b1;
        if (cyc == 70) fval = 1'b0;
        gvld = (cyc >= 45 && cyc < 60);
        gray = 8'($urandom_range(255));
      end
      tick();
      cyc++;
    end
    gvld = 1'b0; fval = 1'b0;
    chk("done_lat", cyc, 259);
    chk("done_b", bus_b.oDone, 1);
    chk("thr_a", bus_a.oThresh, model_thresh(192000));
    chk("thr_b", bus_b.oThresh, model_thresh(10));
    chk("max_a", bus_a.oMaxValue, model_max());
    chk("max_b", bus_b.oMaxValue, model_max());
    tick();
    chk("done_pulse", bus_a.oDone, 0);
    cyc = 0;
    while (bus_a.oBusy === 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("clr_idle", bus_a.oBusy, 0);
    prev_hist = cur_hist;
    exp_bank = ~exp_bank;
  endtask

  initial begin
    int drops0;
    fval = 1'b0; gvld = 1'b0; dreq = 1'b0; gray = '0; daddr = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    reset_checks();
    rst_n = 1'b1;
    init_check();

    // Back-to-back single-bin frame.
    pixq.delete();
    for (int k = 0; k < 1000; k++) pixq.push_back(7);
    run_frame(100, 1'b0, 1'b0);
    read_all();

    // Three bins of four; the small-target instance must pick bin 9.
    pixq.delete();
    for (int k = 0; k < 4; k++) begin pixq.push_back(3); pixq.push_back(5); pixq.push_back(9); end
    run_frame(100, 1'b0, 1'b0);
    chk("thr_b_9", bus_b.oThresh, 9);
    read_all();

    // Half-duty pixels with display requests every cycle.
    fill_rand(300);
    run_frame(50, 1'b1, 1'b0);
    read_all();

    // A frame starts during SCAN and must be dropped without touching the histogram.
    drops0 = drop_cnt;
    fill_rand(200);
    run_frame(70, 1'b1, 1'b1);
    chk("drop_pulse", drop_cnt - drops0, 1);
    read_all();

    fill_rand(250);
    run_frame(50, 1'b1, 1'b0);
    read_all();

    // Frame valid for a single cycle.
    pixq.delete();
    run_frame(50, 1'b1, 1'b0);
    read_all();

    // Reset in the middle of accumulation.
    fval = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      gvld = 1'b1;
      gray = 8'($urandom_range(255));
      tick();
    end
    rst_n = 1'b0;
    #1;
    reset_checks();
    gvld = 1'b0; fval = 1'b0;
    tick();
    rst_n = 1'b1;
    init_check();
    fill_rand(250);
    run_frame(60, 1'b1, 1'b0);
    read_all();
    chk("drops_total", drop_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/histo_frame_sequencer.md
HISTO_FRAME_SEQUENCER -- requirements
Module: histo_frame_sequencer

Interface
REQ-001 Parameter THRESH_TARGET, 20'd192000, cumulative count at which the threshold bin is declared (half of 800x480).
REQ-002 iClk  in  1  sole clock, rising edge.
REQ-003 iRst_n  in  1  reset, asynchronous, active-low.
REQ-004 iFval  in  1  frame valid; rising edge = frame start, falling edge = frame end.
REQ-005 iGray  in  8  gray pixel; iGrayValid  in  1  pixel strobe.
REQ-006 iDispReq  in  1  display read request; iDispAddr  in  8  display bin.
REQ-007 oDispQ  out  20  display bin count; oDispValid  out  1  oDispQ valid.
REQ-008 oRdAddr  out  9  RAM read address {bank,bin}; iRdQ  in  20  RAM read data, latency 1 cycle.
REQ-009 oWrAddr  out  9, oWrData  out  20, oWe  out  1  RAM write port.
REQ-010 oThresh  out  8, oMaxValue  out  20  results of the last completed frame.
REQ-011 oDone  out  1  one-cycle pulse when results update; oFrameDrop  out  1  one-cycle pulse on a skipped frame; oBusy  out  1  high outside IDLE/ACCUM.

Function
REQ-012 States: INIT_CLR, IDLE, ACCUM, DRAIN, SCAN, CLEAR.
REQ-013 INIT_CLR writes zero to all 512 addresses, one per cycle (0..511), then goes to IDLE.
REQ-014 IDLE -> ACCUM on the iFval rising edge; ACCUM -> DRAIN on the iFval falling edge; DRAIN lasts 2 cycles, then SCAN.
REQ-015 A 1-bit accumulate bank register acc_bank selects the bank for ACCUM/SCAN; the display bank is always ~acc_bank.
REQ-016 ACCUM: a valid pixel in cycle t drives oRdAddr={acc_bank,iGray}; in t+1 oWe=1, oWrAddr is the same, and oWrData=iRdQ+1.
REQ-017 When the pixels at t and t+1 hit the same bin, the t+1 increment uses the forwarded t write value, not iRdQ; every pixel is counted exactly once.
REQ-018 Increments saturate at 20'hFFFFF.
REQ-019 SCAN reads bins 0..255 of acc_bank in order over 257 cycles. It keeps a running 20-bit saturating sum and the max bin count. The threshold is the first bin whose sum is >= THRESH_TARGET, or 255 if never reached.
REQ-020 After SCAN: oThresh and oMaxValue update, oDone pulses, acc_bank toggles, and the state becomes CLEAR.
REQ-021 CLEAR writes zero to bins 0..255 of the new acc_bank over 256 cycles, then goes to IDLE.
REQ-022 Read-port priority: ACCUM/SCAN pixel reads first, display second. A display request is granted on any cycle the read port is otherwise free, including IDLE, CLEAR, and ACCUM cycles without iGrayValid.
REQ-023 A granted display read in cycle t yields oDispValid=1 and oDispQ=iRdQ in t+1. An ungranted request gives oDispValid=0; the requester retries.
REQ-024 An iFval rising edge seen in DRAIN/SCAN/CLEAR/INIT_CLR causes that whole frame to be skipped: no accumulation, oFrameDrop pulses once, and the block waits for the next rising edge in IDLE.
REQ-025 iGrayValid outside ACCUM is ignored. iFval rising and falling in consecutive cycles still passes through DRAIN/SCAN/CLEAR.

Reset
REQ-026 On iRst_n low, asynchronously: state=INIT_CLR, acc_bank=0, counters=0, oThresh=8'd0, oMaxValue=0, oDispQ=0, and oDispValid, oWe, oDone, oFrameDrop=0; oBusy=1.
REQ-027 A reset mid-frame or mid-scan discards all partial results; no oDone pulse follows until a full frame completes after INIT_CLR.

Structure
REQ-028 The shared package holds the state enum, HIST_BINS=256, BIN_W=20, and GRAY_W=8.
REQ-029 A single sub-module, histo_rmw_pipe, holds the REQ-016/017/018 read-modify-write with forwarding. Arbitration and the FSM stay in the top level.

Verification
REQ-030 Reset release -> oWe high for 512 cycles writing 0 to 0..511, then oBusy=0.
REQ-031 Frame of 1000 pixels all gray=7 back-to-back -> bin 7 = 1000, others 0; oMaxValue=1000, oThresh=255 with default target.
REQ-032 THRESH_TARGET=10, frame with bins 3,5,9 = 4 each -> oThresh=9, oMaxValue=4, oDone one pulse 259 cycles after DRAIN entry.
REQ-033 Display requests every cycle during an ACCUM with iGrayValid 50% duty -> grants only on pixel-free cycles; oDispQ matches the previous frame's counts.
REQ-034 iFval rise during SCAN -> oFrameDrop pulse, histogram of next frame unaffected, acc_bank alternates only on completed frames.
REQ-035 iRst_n low mid-ACCUM -> all outputs at reset values immediately, INIT_CLR runs, and the next full frame gives correct counts.
